// File: rtl/tlb_refill_pkg.sv
// tlb_refill_pkg
//   Shared types and helpers for the TLB refill controller.
//   refill_state_e : refill sequencer states
//   idx_w()        : index width for an N-entry TLB (at least 1 bit)
package tlb_refill_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    WRITE = 3'd4
  } refill_state_e;

  function automatic int idx_w(input int entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

endpackage

// File: rtl/tlb_victim_sel.sv
// tlb_victim_sel
//   Picks the refill victim: lowest-index invalid entry, or the PLRU
//   suggestion once every entry is valid.
//   valid      in  ENTRIES  entry valid bitmap
//   repl_idx   in  IDX_W    PLRU victim suggestion
//   victim_idx out IDX_W    selected victim
//   all_valid  out 1        every entry valid (victim came from PLRU)
module tlb_victim_sel
  import tlb_refill_pkg::*;
#(
  parameter int ENTRIES = 8,
  parameter int IDX_W   = idx_w(ENTRIES)
) (
  input  logic [ENTRIES-1:0] valid,
  input  logic [IDX_W-1:0]   repl_idx,
  output logic [IDX_W-1:0]   victim_idx,
  output logic               all_valid
);

  logic [IDX_W-1:0] first_free;

  // Scan from the top down so the lowest free index is the last one written.
  always_comb begin
    first_free = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid[i]) first_free = IDX_W'(i);
    end
    all_valid  = &valid;
    victim_idx = all_valid ? repl_idx : first_free;
  end

endmodule

// File: rtl/tlb_refill_ctrl.sv
// tlb_refill_ctrl
//   Refill sequencer for a fully-associative TLB. Accepts a lookup miss,
//   issues a page-table walk, writes the victim entry, and owns the entry
//   valid bitmap and the PLRU update port.
//   Optional build macro TLB_REFILL_PERF_EN adds refill/evict counters.
//
//   clk_i, rstn_i                     clock, synchronous active-low reset
//   miss_valid_i/ready_o/vpn_i        miss request handshake
//   lookup_hit_i, lookup_idx_i        lookup hit to forward to PLRU
//   flush_i                           invalidate all, abort refill
//   ptw_req_valid_o/ready_i/vpn_o     walk request
//   ptw_resp_valid_i, ptw_resp_error_i walk response
//   plru_hit_o, plru_idx_o            PLRU update port
//   plru_repl_idx_i                   PLRU victim suggestion
//   wr_en_o, wr_idx_o, wr_vpn_o       TLB entry write
//   valid_o                           entry valid bitmap
//   refill_done_o, refill_err_o       completion pulses
//   refill_cnt_o, evict_cnt_o         perf counters (TLB_REFILL_PERF_EN)
//
// state | meaning
// IDLE  | ready for a miss
// REQ   | walk request held until PTW accepts
// WAIT  | walk outstanding
// DRAIN | flushed while walking; swallow the next response
// WRITE | one-cycle entry write + PLRU update
module tlb_refill_ctrl
  import tlb_refill_pkg::*;
#(
  parameter int ENTRIES = 8,
  parameter int VPN_W   = 27,
  parameter int CNT_W   = 32,
  localparam int IDX_W  = idx_w(ENTRIES)
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               miss_valid_i,
  output logic               miss_ready_o,
  input  logic [VPN_W-1:0]   miss_vpn_i,
  input  logic               lookup_hit_i,
  input  logic [IDX_W-1:0]   lookup_idx_i,
  input  logic               flush_i,
  output logic               ptw_req_valid_o,
  input  logic               ptw_req_ready_i,
  output logic [VPN_W-1:0]   ptw_req_vpn_o,
  input  logic               ptw_resp_valid_i,
  input  logic               ptw_resp_error_i,
  output logic               plru_hit_o,
  output logic [IDX_W-1:0]   plru_idx_o,
  input  logic [IDX_W-1:0]   plru_repl_idx_i,
  output logic               wr_en_o,
  output logic [IDX_W-1:0]   wr_idx_o,
  output logic [VPN_W-1:0]   wr_vpn_o,
  output logic [ENTRIES-1:0] valid_o,
  output logic               refill_done_o,
  output logic               refill_err_o
`ifdef TLB_REFILL_PERF_EN
  ,
  output logic [CNT_W-1:0]   refill_cnt_o,
  output logic [CNT_W-1:0]   evict_cnt_o
`endif
);

  refill_state_e      state, state_nxt;
  logic [VPN_W-1:0]   vpn_q;
  logic [ENTRIES-1:0] valid_q;
  logic [IDX_W-1:0]   victim;
  logic               all_valid;
  logic               miss_fire;
  logic               write_fire;

  tlb_victim_sel #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_victim_sel (
    .valid      (valid_q),
    .repl_idx   (plru_repl_idx_i),
    .victim_idx (victim),
    .all_valid  (all_valid)
  );

  assign miss_ready_o    = (state == IDLE) && !flush_i;
  assign miss_fire       = miss_valid_i && miss_ready_o;
  assign write_fire      = (state == WRITE) && !flush_i;

  assign ptw_req_valid_o = (state == REQ) && !flush_i;
  assign ptw_req_vpn_o   = vpn_q;

  assign wr_en_o         = write_fire;
  assign wr_idx_o        = victim;
  assign wr_vpn_o        = vpn_q;
  assign refill_done_o   = write_fire;
  assign refill_err_o    = (state == WAIT) && !flush_i && ptw_resp_valid_i && ptw_resp_error_i;
  assign valid_o         = valid_q;

  // The refill owns the PLRU port in WRITE; a coincident lookup hit is dropped.
  assign plru_hit_o      = (state == WRITE) ? write_fire : lookup_hit_i;
  assign plru_idx_o      = (state == WRITE) ? victim     : lookup_idx_i;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (miss_fire) state_nxt = REQ;
      REQ: begin
        if (flush_i)              state_nxt = IDLE;
        else if (ptw_req_ready_i) state_nxt = WAIT;
      end
      WAIT: begin
        // A response arriving with the flush is already consumed; only an
        // outstanding walk needs draining.
        if (flush_i)               state_nxt = ptw_resp_valid_i ? IDLE : DRAIN;
        else if (ptw_resp_valid_i) state_nxt = ptw_resp_error_i ? IDLE : WRITE;
      end
      DRAIN: if (!flush_i && ptw_resp_valid_i) state_nxt = IDLE;
      WRITE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state   <= IDLE;
      vpn_q   <= '0;
      valid_q <= '0;
    end else begin
      state <= state_nxt;
      if (miss_fire) vpn_q <= miss_vpn_i;
      if (flush_i)         valid_q         <= '0;
      else if (write_fire) valid_q[victim] <= 1'b1;
    end
  end

`ifdef TLB_REFILL_PERF_EN
  logic [CNT_W-1:0] refill_cnt_q, evict_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      refill_cnt_q <= '0;
      evict_cnt_q  <= '0;
    end else if (write_fire) begin
      refill_cnt_q <= refill_cnt_q + 1'b1;
      if (all_valid) evict_cnt_q <= evict_cnt_q + 1'b1;
    end
  end

  assign refill_cnt_o = refill_cnt_q;
  assign evict_cnt_o  = evict_cnt_q;
`endif

endmodule

// File: tb/tb_tlb_refill_ctrl.sv
module tb_tlb_refill_ctrl;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        miss_valid_i;
  logic        miss_ready_o;
  logic [26:0] miss_vpn_i;
  logic        lookup_hit_i;
  logic [2:0]  lookup_idx_i;
  logic        flush_i;
  logic        ptw_req_valid_o;
  logic        ptw_req_ready_i;
  logic [26:0] ptw_req_vpn_o;
  logic        ptw_resp_valid_i;
  logic        ptw_resp_error_i;
  logic        plru_hit_o;
  logic [2:0]  plru_idx_o;
  logic [2:0]  plru_repl_idx_i;
  logic        wr_en_o;
  logic [2:0]  wr_idx_o;
  logic [26:0] wr_vpn_o;
  logic [7:0]  valid_o;
  logic        refill_done_o;
  logic        refill_err_o;
`ifdef TLB_REFILL_PERF_EN
  logic [31:0] refill_cnt_o;
  logic [31:0] evict_cnt_o;
`endif

  // standalone victim selector, for bitmaps the controller cannot reach
  logic [7:0]  vs_valid;
  logic [2:0]  vs_repl;
  logic [2:0]  vs_victim;
  logic        vs_all;

  int n_pass  = 0;
  int n_total = 0;

  // reference model state
  logic [7:0]  m_valid;
  int          m_refills;
  int          m_evicts;

  always #5 clk_i = ~clk_i;

  tlb_refill_ctrl dut (
    .clk_i            (clk_i),
    .rstn_i           (rstn_i),
    .miss_valid_i     (miss_valid_i),
    .miss_ready_o     (miss_ready_o),
    .miss_vpn_i       (miss_vpn_i),
    .lookup_hit_i     (lookup_hit_i),
    .lookup_idx_i     (lookup_idx_i),
    .flush_i          (flush_i),
    .ptw_req_valid_o  (ptw_req_valid_o),
    .ptw_req_ready_i  (ptw_req_ready_i),
    .ptw_req_vpn_o    (ptw_req_vpn_o),
    .ptw_resp_valid_i (ptw_resp_valid_i),
    .ptw_resp_error_i (ptw_resp_error_i),
    .plru_hit_o       (plru_hit_o),
    .plru_idx_o       (plru_idx_o),
    .plru_repl_idx_i  (plru_repl_idx_i),
    .wr_en_o          (wr_en_o),
    .wr_idx_o         (wr_idx_o),
    .wr_vpn_o         (wr_vpn_o),
    .valid_o          (valid_o),
    .refill_done_o    (refill_done_o),
    .refill_err_o     (refill_err_o)
`ifdef TLB_REFILL_PERF_EN
    ,
    .refill_cnt_o     (refill_cnt_o),
    .evict_cnt_o      (evict_cnt_o)
`endif
  );

  tlb_victim_sel #(.ENTRIES(8)) u_vs (
    .valid      (vs_valid),
    .repl_idx   (vs_repl),
    .victim_idx (vs_victim),
    .all_valid  (vs_all)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // reference victim: first free slot counting up from 0, PLRU pick when full
  function automatic logic [2:0] ref_victim(input logic [7:0] v, input logic [2:0] repl);
    if (v == 8'hFF) return repl;
    for (int i = 0; i < 8; i++) if (!v[i]) return 3'(i);
    return 3'd0;
  endfunction

  task automatic idle_inputs();
    miss_valid_i     = 1'b0;
    lookup_hit_i     = 1'b0;
    flush_i          = 1'b0;
    ptw_req_ready_i  = 1'b0;
    ptw_resp_valid_i = 1'b0;
    ptw_resp_error_i = 1'b0;
  endtask

  task automatic check_perf();
`ifdef TLB_REFILL_PERF_EN
    chk("refill_cnt", refill_cnt_o, 32'(m_refills));
    chk("evict_cnt", evict_cnt_o, 32'(m_evicts));
`endif
  endtask

  // accept a miss and get the request accepted by the PTW: ends in the walk-wait state
  task automatic to_wait(input logic [26:0] vpn);
    miss_valid_i = 1'b1;
    miss_vpn_i   = vpn;
    tick();
    miss_valid_i    = 1'b0;
    miss_vpn_i      = 27'($urandom);
    ptw_req_ready_i = 1'b1;
    tick();
    ptw_req_ready_i = 1'b0;
  endtask

  // full refill; repl < 0 means a random PLRU suggestion
  task automatic refill(input logic [26:0] vpn, input int rdly, input int pdly,
                        input bit err, input int repl, input bit hit_in_write);
    logic [2:0] exp_idx;
    logic       hit;
    logic [2:0] hidx;
    miss_valid_i = 1'b1;
    miss_vpn_i   = vpn;
    #1;
    chk("miss_ready_idle", 32'(miss_ready_o), 1);
    tick();
    miss_valid_i = 1'b0;
    miss_vpn_i   = 27'($urandom);
    for (int i = 0; i < rdly; i++) begin
      hit          = 1'($urandom_range(0, 1));
      hidx         = 3'($urandom_range(0, 7));
      lookup_hit_i = hit;
      lookup_idx_i = hidx;
      #1;
      chk("req_valid_held", 32'(ptw_req_valid_o), 1);
      chk("req_vpn", 32'(ptw_req_vpn_o), 32'(vpn));
      chk("plru_fwd_hit", 32'(plru_hit_o), 32'(hit));
      if (hit) chk("plru_fwd_idx", 32'(plru_idx_o), 32'(hidx));
      tick();
    end
    lookup_hit_i    = 1'b0;
    ptw_req_ready_i = 1'b1;
    #1;
    chk("req_valid", 32'(ptw_req_valid_o), 1);
    chk("req_vpn_acc", 32'(ptw_req_vpn_o), 32'(vpn));
    tick();
    ptw_req_ready_i = 1'b0;
    for (int i = 0; i < pdly; i++) begin
      #1;
      chk("wait_no_wr", 32'(wr_en_o | refill_err_o | ptw_req_valid_o), 0);
      tick();
    end
    ptw_resp_valid_i = 1'b1;
    ptw_resp_error_i = err;
    #1;
    chk("refill_err", 32'(refill_err_o), 32'(err));
    tick();
    ptw_resp_valid_i = 1'b0;
    ptw_resp_error_i = 1'b0;
    if (err) begin
      #1;
      chk("err_wr_en", 32'(wr_en_o), 0);
      chk("err_valid_keep", 32'(valid_o), 32'(m_valid));
      chk("err_back_idle", 32'(miss_ready_o), 1);
    end else begin
      plru_repl_idx_i = (repl < 0) ? 3'($urandom_range(0, 7)) : 3'(repl);
      lookup_hit_i    = hit_in_write;
      lookup_idx_i    = 3'd2;
      exp_idx         = ref_victim(m_valid, plru_repl_idx_i);
      #1;
      chk("wr_en", 32'(wr_en_o), 1);
      chk("refill_done", 32'(refill_done_o), 1);
      chk("wr_idx", 32'(wr_idx_o), 32'(exp_idx));
      chk("wr_vpn", 32'(wr_vpn_o), 32'(vpn));
      chk("plru_hit_wr", 32'(plru_hit_o), 1);
      chk("plru_idx_wr", 32'(plru_idx_o), 32'(exp_idx));
      m_refills++;
      if (m_valid == 8'hFF) m_evicts++;
      m_valid[exp_idx] = 1'b1;
      tick();
      lookup_hit_i = 1'b0;
      #1;
      chk("valid_after_wr", 32'(valid_o), 32'(m_valid));
      chk("done_one_pulse", 32'(refill_done_o | wr_en_o), 0);
      chk("idle_after_wr", 32'(miss_ready_o), 1);
      check_perf();
    end
  endtask

  initial begin
    rstn_i          = 1'b0;
    idle_inputs();
    miss_vpn_i      = '0;
    lookup_idx_i    = '0;
    plru_repl_idx_i = '0;
    vs_valid        = '0;
    vs_repl         = '0;
    m_valid         = '0;
    m_refills       = 0;
    m_evicts        = 0;
    tick();
    tick();
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_req_valid", 32'(ptw_req_valid_o), 0);
    chk("rst_wr_en", 32'(wr_en_o), 0);
    chk("rst_pulses", 32'({refill_done_o, refill_err_o}), 0);
    chk("rst_plru_hit", 32'(plru_hit_o), 0);
    chk("rst_req_vpn", 32'(ptw_req_vpn_o), 0);
    chk("rst_miss_ready", 32'(miss_ready_o), 1);
    rstn_i = 1'b1;
    tick();
    check_perf();

    // empty TLB, fastest refill -> slot 0
    refill(27'h123, 0, 0, 1'b0, -1, 1'b0);
    chk("first_valid", 32'(valid_o), 32'h01);

    // faulting walk leaves the bitmap alone
    refill(27'h456, 1, 2, 1'b1, -1, 1'b0);

    // random refills: fills the table then exercises PLRU eviction
    for (int k = 0; k < 30; k++)
      refill(27'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
             ($urandom_range(0, 3) == 0), -1, 1'($urandom_range(0, 1)));

    // full table, PLRU suggests 5, lookup hit on 2 in the write cycle is dropped
    chk("table_full", 32'(valid_o), 32'hFF);
    refill(27'h7ABCD, 0, 1, 1'b0, 5, 1'b1);

    // flush in IDLE with a miss: not accepted, table cleared
    miss_valid_i = 1'b1;
    flush_i      = 1'b1;
    #1;
    chk("flush_idle_ready", 32'(miss_ready_o), 0);
    tick();
    miss_valid_i = 1'b0;
    flush_i      = 1'b0;
    m_valid      = '0;
    #1;
    chk("flush_idle_noreq", 32'(ptw_req_valid_o), 0);
    chk("flush_idle_valid", 32'(valid_o), 0);
    check_perf();

    refill(27'h11, 0, 0, 1'b0, -1, 1'b0);
    refill(27'h22, 0, 0, 1'b0, -1, 1'b0);

    // flush while requesting
    miss_valid_i = 1'b1;
    miss_vpn_i   = 27'h33;
    tick();
    miss_valid_i = 1'b0;
    flush_i      = 1'b1;
    #1;
    chk("flush_req_drop", 32'(ptw_req_valid_o), 0);
    tick();
    flush_i = 1'b0;
    m_valid = '0;
    #1;
    chk("flush_req_idle", 32'(miss_ready_o), 1);
    chk("flush_req_valid", 32'(valid_o), 0);

    // flush in WAIT, late response swallowed
    refill(27'h44, 0, 0, 1'b0, -1, 1'b0);
    to_wait(27'h55);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    m_valid = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("drain_not_ready", 32'(miss_ready_o), 0);
      tick();
    end
    ptw_resp_valid_i = 1'b1;
    #1;
    chk("drain_no_pulse", 32'({wr_en_o, refill_done_o, refill_err_o}), 0);
    tick();
    ptw_resp_valid_i = 1'b0;
    #1;
    chk("drain_done_ready", 32'(miss_ready_o), 1);
    chk("drain_valid", 32'(valid_o), 0);
    chk("drain_no_wr", 32'(wr_en_o), 0);
    refill(27'h66, 0, 0, 1'b0, -1, 1'b0);
    chk("after_drain_slot0", 32'(valid_o), 32'h01);

    // flush coincident with a (faulting) response in WAIT
    to_wait(27'h77);
    flush_i          = 1'b1;
    ptw_resp_valid_i = 1'b1;
    ptw_resp_error_i = 1'b1;
    #1;
    chk("flush_resp_noerr", 32'(refill_err_o), 0);
    tick();
    idle_inputs();
    m_valid = '0;
    #1;
    chk("flush_resp_idle", 32'(miss_ready_o), 1);

    // flush in WRITE: write and PLRU update suppressed
    refill(27'h88, 0, 0, 1'b0, -1, 1'b0);
    to_wait(27'h99);
    ptw_resp_valid_i = 1'b1;
    tick();
    ptw_resp_valid_i = 1'b0;
    flush_i          = 1'b1;
    lookup_hit_i     = 1'b1;
    #1;
    chk("flush_wr_en", 32'({wr_en_o, refill_done_o}), 0);
    chk("flush_wr_plru", 32'(plru_hit_o), 0);
    tick();
    idle_inputs();
    m_valid = '0;
    #1;
    chk("flush_wr_valid", 32'(valid_o), 0);
    chk("flush_wr_idle", 32'(miss_ready_o), 1);
    check_perf();

    // reset while a walk is outstanding
    refill(27'hAA, 0, 0, 1'b0, -1, 1'b0);
    to_wait(27'hBB);
    rstn_i = 1'b0;
    tick();
    rstn_i    = 1'b1;
    m_valid   = '0;
    m_refills = 0;
    m_evicts  = 0;
    ptw_resp_valid_i = 1'b1;
    #1;
    chk("rst_mid_ready", 32'(miss_ready_o), 1);
    chk("rst_mid_valid", 32'(valid_o), 0);
    chk("rst_mid_no_wr", 32'({wr_en_o, refill_err_o}), 0);
    tick();
    ptw_resp_valid_i = 1'b0;
    #1;
    chk("rst_mid_stay", 32'(wr_en_o), 0);
    check_perf();
    refill(27'hCC, 1, 1, 1'b0, -1, 1'b0);

    // victim selector on arbitrary bitmaps
    vs_valid = 8'hF7;
    for (int r = 0; r < 8; r++) begin
      vs_repl = 3'(r);
      #1;
      chk("vs_f7", 32'(vs_victim), 3);
    end
    for (int k = 0; k < 20; k++) begin
      vs_valid = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      vs_repl  = 3'($urandom_range(0, 7));
      #1;
      chk("vs_rand", 32'(vs_victim), 32'(ref_victim(vs_valid, vs_repl)));
      chk("vs_all", 32'(vs_all), 32'(vs_valid == 8'hFF));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
